// File: rtl/seg7_pkg.sv
// seg7_pkg: digit count and seven-segment glyph constants (bit0 = a .. bit6 = g)
package seg7_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF = 7'h00;
endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: digit inputs from the counter stages and multiplexed display outputs
interface seg7_scan_if;
  logic en;
  logic [7:0] d0, d1, d2, d3, d4, d5;
  logic blank_lz;
  logic [5:0] dp_mask;
  logic [6:0] seg;
  logic dp;
  logic [5:0] an;
  logic frame;
  modport master (output en, d0, d1, d2, d3, d4, d5, blank_lz, dp_mask, input seg, dp, an, frame);
  modport slave (input en, d0, d1, d2, d3, d4, d5, blank_lz, dp_mask, output seg, dp, an, frame);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: binary digit value to segment pattern, dash for anything above 9
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [7:0] v_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (v_i)
      8'd0: seg_o = SEG_0;
      8'd1: seg_o = SEG_1;
      8'd2: seg_o = SEG_2;
      8'd3: seg_o = SEG_3;
      8'd4: seg_o = SEG_4;
      8'd5: seg_o = SEG_5;
      8'd6: seg_o = SEG_6;
      8'd7: seg_o = SEG_7;
      8'd8: seg_o = SEG_8;
      8'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: six-digit multiplexed display scanner with dead-time and per-frame shadow capture
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEADTIME = 4
) (
  input logic clk,
  input logic rst,
  seg7_scan_if.slave io
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [NUM_DIGITS-1:0][7:0] sh_q, sh_d;
  logic lz_q, lz_d;
  logic [NUM_DIGITS-1:0] dpm_q, dpm_d;
  logic [6:0] seg_q, seg_d, dec;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic dp_q, dp_d, frame_q, frame_d;
  logic wrap, last, drive, blank;
  seg7_decode u_dec (.v_i(sh_q[idx_q]), .seg_o(dec));
  always_comb begin
    wrap = cnt_q == CW'(SCAN_DIV - 1);
    last = idx_q == 3'(NUM_DIGITS - 1);
    cnt_d = !io.en ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    idx_d = !(io.en && wrap) ? idx_q : last ? '0 : idx_q + 1'b1;
    frame_d = io.en && wrap && last;
    sh_d = frame_d ? {io.d5, io.d4, io.d3, io.d2, io.d1, io.d0} : sh_q;
    lz_d = frame_d ? io.blank_lz : lz_q;
    dpm_d = frame_d ? io.dp_mask : dpm_q;
    // the anodes go dark for the first DEADTIME cycles of every slot to avoid ghosting
    drive = io.en && cnt_q >= CW'(DEADTIME);
    blank = lz_q && last && sh_q[NUM_DIGITS-1] == '0;
    seg_d = (!drive || blank) ? SEG_OFF : dec;
    dp_d = drive && dpm_q[idx_q];
    an_d = drive ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      lz_q <= 1'b0;
      dpm_q <= '0;
      seg_q <= SEG_OFF;
      dp_q <= 1'b0;
      an_q <= '1;
      frame_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      lz_q <= lz_d;
      dpm_q <= dpm_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_q <= an_d;
      frame_q <= frame_d;
    end
  end
  assign io.seg = seg_q;
  assign io.dp = dp_q;
  assign io.an = an_q;
  assign io.frame = frame_q;
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per digit slot; SCAN_DIV SHALL be at least DEADTIME+2.
REQ-002 Parameter DEADTIME, default 4: cycles at the start of each slot with all anodes off.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  scan enable; low SHALL freeze the scan and blank the display.
REQ-006 d0..d5  in  8 each  digit values from the counter stages (d0 = seconds units, d5 = hours tens), unsigned binary.
REQ-007 blank_lz  in  1  leading-zero blanking request for d5.
REQ-008 dp_mask  in  6  decimal-point enable per digit; bit i maps to digit i.
REQ-009 seg  out  7  segments a..g, active-high; bit0 = a, bit6 = g.
REQ-010 dp  out  1  decimal point, active-high.
REQ-011 an  out  6  digit select, one-hot active-low; bit i maps to digit i.
REQ-012 frame  out  1  one-cycle pulse marking the start of a new scan frame.

Function
REQ-013 Prescaler cnt SHALL count 0..SCAN_DIV-1 while en=1 and wrap to 0.
REQ-014 Digit index idx (0..5) SHALL advance by 1 when cnt=SCAN_DIV-1, wrapping from 5 to 0.
REQ-015 On the idx 5->0 transition, d0..d5, blank_lz and dp_mask SHALL be captured into shadow registers in the same edge; mid-frame input changes SHALL NOT reach the outputs before then.
REQ-016 frame SHALL be 1 for exactly the cycle after the shadow capture; otherwise 0.
REQ-017 seg, dp, an and frame SHALL be registered; outputs in cycle t+1 reflect cnt, idx, shadow and en in cycle t.
REQ-018 an SHALL be 6'b111111 when cnt<DEADTIME; otherwise bit idx low and all other bits high.
REQ-019 Segment encoding for a shadow value v: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-020 Any v>9 (upper bits included) SHALL display 0x40 (dash).
REQ-021 If shadow blank_lz=1, idx=5 and shadow d5=0, seg SHALL be 0x00; dp SHALL still follow the mask.
REQ-022 dp SHALL equal shadow dp_mask[idx] while the digit is driven; 0 during dead-time.
REQ-023 seg SHALL be 0x00 during dead-time.
REQ-024 With en=0, cnt and idx SHALL hold; an=6'b111111, seg=0, dp=0, frame=0; no shadow capture.
REQ-025 When en returns to 1, scanning SHALL resume from the held cnt/idx with no restart of the slot.

Reset
REQ-026 With rst=1 at an edge: cnt=0, idx=0, shadow digits=0, shadow blank_lz=0, shadow dp_mask=0, seg=0, dp=0, an=6'b111111, frame=0.
REQ-027 rst SHALL take priority over en in every cycle, including mid-slot and mid-frame.
REQ-028 The first capture after reset SHALL occur at the first 5->0 wrap; digit 0 is displayed from shadow zero until then.

Structure
REQ-029 Package seg7_pkg SHALL hold NUM_DIGITS=6, the ten segment constants, SEG_DASH=0x40 and SEG_OFF=0x00.
REQ-030 Sub-module seg7_decode SHALL implement the combinational value-to-segment map (REQ-019, REQ-020), instantiated once on the shadow value selected by idx.

Verification (SCAN_DIV=8, DEADTIME=2)
REQ-031 Reset, then en=1 with d0..d5 = 1..6 for 2 frames -> second frame: an walks 111110..011111; each slot shows 2 off cycles then 6 driven cycles; seg = 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D.
REQ-032 Change d0 from 1 to 7 during idx=3 -> digit 0 shows 0x06 until the frame pulse, then 0x07.
REQ-033 d5=0, blank_lz=1, dp_mask=6'b000100 -> digit 5 seg=0x00; digit 2 dp=1; all other dp=0.
REQ-034 d3=12, then d3=0x8A -> digit 3 seg=0x40 for both values.
REQ-035 Drop en for 10 cycles at cnt=4, idx=2 -> an=111111, seg=0 throughout; on resume cnt=5, idx=2, with no frame pulse.
REQ-036 Assert rst at idx=4 -> next cycle an=111111 and frame=0; the scan restarts at idx=0 showing shadow 0x3F.
